// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared types and constants for the ALU arbiter slice.
//   state_t  - arbiter FSM states
//   NUM_REQ  - number of requesters sharing the ALU
//   OP_IMM / OP_REG - RV32 opcode fields understood by alu_r32
package alu_arbiter_pkg;

    localparam int NUM_REQ = 2;

    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: combinational two-way round-robin grant.
//   req       in  per-requester request
//   prio      in  requester that wins when both request
//   enable    in  grant allowed this cycle
//   grant     out one-hot grant (all zero when disabled or no request)
//   grant_idx out index of the winning requester
// Holds no state; the caller owns and advances prio.
module rr_arbiter_2
    import alu_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               prio,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic               grant_idx
);

    always_comb begin
        // Requester 1 wins when it is alone or when both request and it holds priority.
        grant_idx = req[1] & (~req[0] | prio);
        grant     = '0;
        if (enable && (req != '0)) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one single-cycle alu_r32 between the execute stage (req 0)
// and the debug port (req 1). One operation in flight at a time.
//   clk, rst                  clock, asynchronous active-low reset
//   req_*_i / req_ready_o     per-requester valid/ready request channel
//   rsp_*                     valid/ready response with result, requester id and tag
//   alu_data1/2_o, alu_op_o   registered operands driving alu_r32
//   alu_result_i              combinational alu_r32 result
//   op_count_o                completed response handshakes (wraps)
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ-1:0][XLEN-1:0]    req_data1_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]    req_data2_i,
    input  logic [NUM_REQ-1:0][XLEN-1:0]    req_op_i,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [XLEN-1:0]                 rsp_result_o,
    output logic                            rsp_id_o,
    output logic [TAG_W-1:0]                rsp_tag_o,
    output logic [XLEN-1:0]                 alu_data1_o,
    output logic [XLEN-1:0]                 alu_data2_o,
    output logic [XLEN-1:0]                 alu_op_o,
    input  logic [XLEN-1:0]                 alu_result_i,
    output logic [CNT_W-1:0]                op_count_o
);

    state_t             state;
    logic               prio;
    logic [NUM_REQ-1:0] grant;
    logic               gidx;

    rr_arbiter_2 u_arb (
        .req       (req_valid_i),
        .prio      (prio),
        .enable    (state == IDLE),
        .grant     (grant),
        .grant_idx (gidx)
    );

    assign req_ready_o = grant;
    assign rsp_valid_o = (state == RESP);

    // id and tag are captured at accept time so they stay stable through RESP
    // regardless of what the requesters present afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            prio         <= 1'b0;
            alu_data1_o  <= '0;
            alu_data2_o  <= '0;
            alu_op_o     <= '0;
            rsp_result_o <= '0;
            rsp_id_o     <= 1'b0;
            rsp_tag_o    <= '0;
            op_count_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != '0) begin
                        alu_data1_o <= req_data1_i[gidx];
                        alu_data2_o <= req_data2_i[gidx];
                        alu_op_o    <= req_op_i[gidx];
                        rsp_tag_o   <= req_tag_i[gidx];
                        rsp_id_o    <= gidx;
                        prio        <= ~gidx;
                        state       <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result_o <= alu_result_i;
                    state        <= RESP;
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        op_count_o <= op_count_o + CNT_W'(1);
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
